// File: rtl/btn_cmd_encoder_if.sv
// Button and command bundle for btn_cmd_encoder.
// master drives raw buttons, slave drives the command outputs.
interface btn_cmd_encoder_if;
  logic btn_set;
  logic btn_clr;
  logic btn_tgl;
  logic B1;
  logic B2;
  logic cmd_valid;
  logic conflict;
  logic q_model;

  modport master (
    output btn_set,
    output btn_clr,
    output btn_tgl,
    input  B1,
    input  B2,
    input  cmd_valid,
    input  conflict,
    input  q_model
  );

  modport slave (
    input  btn_set,
    input  btn_clr,
    input  btn_tgl,
    output B1,
    output B2,
    output cmd_valid,
    output conflict,
    output q_model
  );
endinterface

// File: rtl/btn_cmd_encoder.sv
// Raw set/clear/toggle buttons to a one-cycle B1/B2 command,
// with a reference model of the downstream flip-flop Q.
module btn_cmd_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input logic             clk,
  input logic             rst,
  btn_cmd_encoder_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // index 0 = set, 1 = clear, 2 = toggle
  logic [2:0]       raw;
  logic [2:0]       s1;
  logic [2:0]       s2;
  logic [2:0]       stable;
  logic [CNT_W-1:0] cnt [3];
  logic [2:0]       hit;
  logic [2:0]       press;

  logic [1:0] cmd;
  logic       valid;
  logic       confl;
  logic       q;

  logic [1:0] nxt_cmd;
  logic       nxt_valid;
  logic       nxt_confl;

  assign raw = {bus.btn_tgl, bus.btn_clr, bus.btn_set};

  // Debounce threshold reached this cycle; a 0->1 load is a press.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      hit[i]   = (s2[i] != stable[i]) && (cnt[i] == LAST);
      press[i] = hit[i] & s2[i];
    end
  end

  // Sync, debounce and level tracking for all three buttons.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= '0;
      s2     <= '0;
      stable <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < 3; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (hit[i]) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Set and clear beat toggle; set with clear is rejected.
  always_comb begin
    nxt_cmd   = 2'b00;
    nxt_valid = 1'b0;
    nxt_confl = 1'b0;
    unique case (1'b1)
      press[0] & press[1]: begin
        nxt_confl = 1'b1;
      end
      press[0] & ~press[1]: begin
        nxt_cmd   = 2'b11;
        nxt_valid = 1'b1;
      end
      press[1] & ~press[0]: begin
        nxt_cmd   = 2'b01;
        nxt_valid = 1'b1;
      end
      press[2] & ~press[0] & ~press[1]: begin
        nxt_cmd   = 2'b10;
        nxt_valid = 1'b1;
      end
      default: begin
        nxt_cmd = 2'b00;
      end
    endcase
  end

  // Register the command; q follows what the flop consumes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd   <= 2'b00;
      valid <= 1'b0;
      confl <= 1'b0;
      q     <= 1'b0;
    end else begin
      cmd   <= nxt_cmd;
      valid <= nxt_valid;
      confl <= nxt_confl;
      unique case (cmd)
        2'b01:   q <= 1'b0;
        2'b10:   q <= ~q;
        2'b11:   q <= 1'b1;
        default: q <= q;
      endcase
    end
  end

  assign bus.B1        = cmd[1];
  assign bus.B2        = cmd[0];
  assign bus.cmd_valid = valid;
  assign bus.conflict  = confl;
  assign bus.q_model   = q;

endmodule
